ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It consumes the ALU-operand fields that the ID/EX pipeline register delivers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. While an operation runs it raises `out_busy`, which tells the hazard unit to stall any dependent MFHI/MFLO or any new mul/div instruction.

## Interface
- No parameters; datapath fixed at 32 bits, HI/LO 32 bits each.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low
- `in_start`  input  1  EX-stage instruction is a mul/div/MTHI/MTLO op (decoded from ID/EX control)
- `in_funct`  input  6  funct field from ID/EX
- `in_ReadData1`  input  32  rs operand (post-forwarding)
- `in_ReadData2`  input  32  rt operand (post-forwarding)
- `in_kill`  input  1  abort in-flight operation (branch flush/exception)
- `out_busy`  output  1  registered; high while an operation is in flight
- `out_done`  output  1  one-cycle pulse when HI/LO have been updated by a mul/div
- `out_HI`  output  32  HI register (feeds MFHI mux)
- `out_LO`  output  32  LO register (feeds MFLO mux)

## Operation
- **Reset values:** HI=0, LO=0, out_busy=0, out_done=0, state IDLE, iteration counter 0.
- **Recognised funct codes:** MTHI 0x11, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other funct with in_start=1 is ignored.
- **State machine:**
  - IDLE -> RUN when a mul/div is accepted.
  - IDLE -> FIXUP when a DIV/DIVU is accepted with rt==0.
  - RUN -> FIXUP when the counter reaches 0.
  - FIXUP -> IDLE always.
  - Any state -> IDLE when in_kill=1.
- **Accept:** in IDLE, in_start=1 with a mul/div funct latches the operands.
  - Signed ops (MULT, DIV) latch absolute values and record the result sign(s).
  - Unsigned ops latch the operands raw.
  - The counter is set to 31.
- **RUN, multiply:** one shift-add step per cycle into a 64-bit accumulator.
- **RUN, divide:** one restoring-divide step per cycle with a 32-bit remainder and a 32-bit quotient.
- **FIXUP:** applies signs and writes HI/LO, pulses out_done.
  - Product is negated (64-bit two's complement) if the operand signs differ.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
- **Divide by zero:** LO=0xFFFFFFFF, HI=dividend (raw rs value), via a direct IDLE->FIXUP path.
- **Signed overflow** (0x80000000 / -1): LO=0x80000000, HI=0. This falls out of the absolute-value path naturally.
- **MTHI/MTLO:** in IDLE, write rs into HI/LO at the next edge. No busy, no done.
- **in_start while busy:** ignored. The hazard unit guarantees this does not happen; the verification engineer asserts it.
- **in_kill:**
  - HI/LO remain unchanged and out_done stays 0.
  - out_busy=0 after the next edge.
  - in_kill has priority over in_start in the same cycle: the op is not accepted.

## Timing
- A mul/div accepted at edge N has:
  - out_busy high from after edge N until after edge N+33 (33 cycles).
  - HI/LO written at edge N+33.
  - out_done high for exactly the cycle after edge N+33.
- A divide by zero has out_busy high for 1 cycle; HI/LO are written and out_done pulses at edge N+1.
- MTHI/MTLO: HI/LO are visible on out_HI/out_LO in the cycle after the accepting edge.
- A back-to-back mul/div may be accepted in the same cycle that out_done is high (state is IDLE).
- Asynchronous reset mid-operation: all outputs return immediately to their reset values, and no partial result is written.
- out_HI/out_LO are direct register outputs; there is no combinational path from the inputs.

## Structure
- Shared `mips_pkg` holds:
  - funct constants (FUNCT_MTHI, FUNCT_MTLO, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU);
  - the muldiv state encoding (IDLE, RUN, FIXUP).
- The single module contains the FSM and datapath; no sub-module.
- The hazard unit consumes out_busy; the EX result mux consumes out_HI/out_LO.

## Test plan
- MULT 7 × 0xFFFFFFFD (-3) -> busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, and done pulses once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> busy for 1 cycle, then LO=0xFFFFFFFF, HI=0x00000064.
- MTHI 0x12345678, then MULT 3×4 killed at cycle 10, then reset asserted during a second MULT:
  - HI=0x12345678 persists after the kill and done never pulses;
  - after reset, HI=LO=0 and busy=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: R-type funct codes for the HI/LO unit and the
// mul/div state encoding.
package mips_pkg;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } md_state_e;

    // Two's complement negate of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit. Owns HI/LO, runs 32 shift-add or
// restoring-divide steps on magnitudes, then applies signs in a FIXUP cycle.
module ex_muldiv_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_start,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_ReadData1,
    input  logic [31:0] in_ReadData2,
    input  logic        in_kill,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_HI,
    output logic [31:0] out_LO
);

    md_state_e   state_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opb_q;      // multiplicand or divisor magnitude
    logic        is_div_q;
    logic        dz_q;
    logic        neg_q;      // operand signs differ
    logic        neg_rem_q;  // dividend was negative
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        op_mul;
    logic        op_div;
    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [63:0] acc_d;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    // Decode the funct field and form operand magnitudes for signed ops.
    always_comb begin
        op_mul    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        case (in_funct)
            FUNCT_MULT:  begin op_mul = 1'b1; op_signed = 1'b1; end
            FUNCT_MULTU: op_mul = 1'b1;
            FUNCT_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
            FUNCT_DIVU:  op_div = 1'b1;
            default:     ;
        endcase
        a_neg = op_signed & in_ReadData1[31];
        b_neg = op_signed & in_ReadData2[31];
        a_abs = a_neg ? neg32(in_ReadData1) : in_ReadData1;
        b_abs = b_neg ? neg32(in_ReadData2) : in_ReadData2;
    end

    // One iteration step: shift-add for multiply, restoring step for divide.
    always_comb begin
        logic [32:0] sum;
        logic [32:0] shifted;
        logic [33:0] diff;
        acc_d   = acc_q;
        sum     = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
        shifted = {acc_q[63:32], acc_q[31]};
        diff    = {1'b0, shifted} - {2'b00, opb_q};
        if (is_div_q) begin
            if (!diff[33]) begin
                acc_d = {diff[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_d = {shifted[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            acc_d = {sum, acc_q[31:1]};
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        logic [63:0] prod;
        prod = neg_q ? (~acc_q + 64'd1) : acc_q;
        hi_d = prod[63:32];
        lo_d = prod[31:0];
        if (dz_q) begin
            hi_d = acc_q[63:32];
            lo_d = acc_q[31:0];
        end else if (is_div_q) begin
            hi_d = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
            lo_d = neg_q     ? neg32(acc_q[31:0])  : acc_q[31:0];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            opb_q     <= 32'd0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (in_kill) begin
                // Abort wins over everything, including a same-cycle start.
                state_q <= IDLE;
                count_q <= 5'd0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (in_start) begin
                            if (in_funct == FUNCT_MTHI) begin
                                hi_q <= in_ReadData1;
                            end else if (in_funct == FUNCT_MTLO) begin
                                lo_q <= in_ReadData1;
                            end else if (op_mul || op_div) begin
                                is_div_q  <= op_div;
                                neg_q     <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                count_q   <= 5'd31;
                                busy_q    <= 1'b1;
                                if (op_div && in_ReadData2 == 32'd0) begin
                                    // Divide by zero skips iteration entirely.
                                    dz_q    <= 1'b1;
                                    acc_q   <= {in_ReadData1, 32'hFFFF_FFFF};
                                    opb_q   <= 32'd0;
                                    state_q <= FIXUP;
                                end else if (op_div) begin
                                    dz_q    <= 1'b0;
                                    acc_q   <= {32'd0, a_abs};
                                    opb_q   <= b_abs;
                                    state_q <= RUN;
                                end else begin
                                    dz_q    <= 1'b0;
                                    acc_q   <= {32'd0, b_abs};
                                    opb_q   <= a_abs;
                                    state_q <= RUN;
                                end
                            end
                        end
                    end
                    RUN: begin
                        acc_q   <= acc_d;
                        count_q <= count_q - 5'd1;
                        if (count_q == 5'd0) begin
                            state_q <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        dz_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_busy = busy_q;
    assign out_done = done_q;
    assign out_HI   = hi_q;
    assign out_LO   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit with hand-computed results.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        in_start;
    logic [5:0]  in_funct;
    logic [31:0] in_ReadData1;
    logic [31:0] in_ReadData2;
    logic        in_kill;
    logic        out_busy;
    logic        out_done;
    logic [31:0] out_HI;
    logic [31:0] out_LO;

    int vec_cnt;
    int err_cnt;

    ex_muldiv_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_start     (in_start),
        .in_funct     (in_funct),
        .in_ReadData1 (in_ReadData1),
        .in_ReadData2 (in_ReadData2),
        .in_kill      (in_kill),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_HI       (out_HI),
        .out_LO       (out_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Drive an op at the current negedge; the next posedge accepts it.
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        in_start     = 1'b1;
        in_funct     = f;
        in_ReadData1 = a;
        in_ReadData2 = b;
    endtask

    // From the negedge after the accepting edge, wait out busy and check results.
    task automatic finish_op(input string tag, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_n;
        int early_done;
        busy_n     = 0;
        early_done = 0;
        while (out_busy === 1'b1 && busy_n < 100) begin
            if (out_done === 1'b1) early_done++;
            busy_n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        check({tag, " early_done"}, 64'(early_done), 64'd0);
        check({tag, " done"}, {63'd0, out_done}, 64'd1);
        check({tag, " HI"}, {32'd0, out_HI}, {32'd0, exp_hi});
        check({tag, " LO"}, {32'd0, out_LO}, {32'd0, exp_lo});
    endtask

    task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int exp_busy,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(negedge clk);
        start_op(f, a, b);
        @(negedge clk);
        in_start = 1'b0;
        finish_op(tag, exp_busy, exp_hi, exp_lo);
        @(negedge clk);
        check({tag, " done_drop"}, {63'd0, out_done}, 64'd0);
    endtask

    // Count done pulses over a window of cycles.
    task automatic watch_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_done === 1'b1) pulses++;
        end
    endtask

    initial begin
        int pulses;
        vec_cnt      = 0;
        err_cnt      = 0;
        reset        = 1'b0;
        in_start     = 1'b0;
        in_funct     = 6'd0;
        in_ReadData1 = 32'd0;
        in_ReadData2 = 32'd0;
        in_kill      = 1'b0;

        repeat (2) @(negedge clk);
        check("rst busy", {63'd0, out_busy}, 64'd0);
        check("rst done", {63'd0, out_done}, 64'd0);
        check("rst HILO", {out_HI, out_LO}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post-rst busy", {63'd0, out_busy}, 64'd0);

        do_op("MULT 7*-3",      6'h18, 32'd7,         32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("MULTU max*max",  6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("MULTU 2^16^2",   6'h19, 32'h0001_0000, 32'h0001_0000, 33, 32'h0000_0001, 32'h0000_0000);
        do_op("DIV -7/2",       6'h1A, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("DIV 7/-2",       6'h1A, 32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        do_op("DIV ovf",        6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
        do_op("DIVU 100/7",     6'h1B, 32'd100,       32'd7,         33, 32'h0000_0002, 32'h0000_000E);
        do_op("DIVU 100/0",     6'h1B, 32'd100,       32'd0,         1,  32'h0000_0064, 32'hFFFF_FFFF);
        do_op("DIV -5/0",       6'h1A, 32'hFFFF_FFFB, 32'd0,         1,  32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Back-to-back: second op accepted in the cycle done is high.
        @(negedge clk);
        start_op(6'h19, 32'd6, 32'd7);
        @(negedge clk);
        in_start = 1'b0;
        finish_op("b2b MULTU 6*7", 33, 32'd0, 32'd42);
        start_op(6'h1B, 32'd50, 32'd8);
        @(negedge clk);
        in_start = 1'b0;
        finish_op("b2b DIVU 50/8", 33, 32'd2, 32'd6);
        @(negedge clk);

        // Unrecognised funct is ignored.
        start_op(6'h20, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        in_start = 1'b0;
        check("bad funct busy", {63'd0, out_busy}, 64'd0);
        check("bad funct HILO", {out_HI, out_LO}, {32'd2, 32'd6});

        // MTHI / MTLO visible the cycle after the accepting edge.
        start_op(6'h11, 32'h1234_5678, 32'd0);
        @(negedge clk);
        in_start = 1'b0;
        check("MTHI HI", {32'd0, out_HI}, {32'd0, 32'h1234_5678});
        check("MTHI busy/done", {62'd0, out_busy, out_done}, 64'd0);
        start_op(6'h13, 32'hCAFE_0001, 32'd0);
        @(negedge clk);
        in_start = 1'b0;
        check("MTLO LO", {32'd0, out_LO}, {32'd0, 32'hCAFE_0001});

        // MULT 3*4 killed in cycle 10: HI/LO untouched, no done.
        start_op(6'h18, 32'd3, 32'd4);
        @(negedge clk);
        in_start = 1'b0;
        repeat (9) @(negedge clk);
        check("kill pre busy", {63'd0, out_busy}, 64'd1);
        in_kill = 1'b1;
        @(negedge clk);
        in_kill = 1'b0;
        check("kill busy", {63'd0, out_busy}, 64'd0);
        watch_done(40, pulses);
        check("kill done pulses", 64'(pulses), 64'd0);
        check("kill HILO", {out_HI, out_LO}, {32'h1234_5678, 32'hCAFE_0001});

        // Kill and start in the same cycle: not accepted.
        start_op(6'h19, 32'd2, 32'd2);
        in_kill = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        in_kill  = 1'b0;
        check("kill+start busy", {63'd0, out_busy}, 64'd0);
        watch_done(40, pulses);
        check("kill+start done", 64'(pulses), 64'd0);

        // Asynchronous reset during a MULT.
        start_op(6'h18, 32'd5, 32'd9);
        @(negedge clk);
        in_start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async rst busy/done", {62'd0, out_busy, out_done}, 64'd0);
        check("async rst HILO", {out_HI, out_LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        watch_done(40, pulses);
        check("post rst done", 64'(pulses), 64'd0);
        check("post rst busy", {63'd0, out_busy}, 64'd0);
        check("post rst HILO", {out_HI, out_LO}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
